// File: rtl/timer_pkg.sv
// timer_pkg: shared state type and sizing helper for the down-counting timer
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} timer_state_e;

    // Prescaler counter width; a divide-by-1 still gets a one-bit register
    function automatic int presc_w(int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides RUN cycles into decrement ticks, one every PRESCALE enabled cycles
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = presc_w(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // With PRESCALE=1 the counter never leaves 0, so tick follows en directly
    assign tick = en && (cnt_q == LAST);

    // Next phase: clear wins, otherwise advance while enabled and wrap on tick
    always_comb begin
        cnt_d = clr ? '0 : en ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/timer_n.sv
// timer_n: loadable down-counting timer with pause, auto-reload, prescaler, tc pulse and sticky irq
module timer_n
    import timer_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         auto_reload,
    input  logic         irq_clr,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         tc,
    output logic         irq
);

    timer_state_e state_q, state_d;
    logic [N-1:0] count_q, count_d, reload_q, reload_d, eff;
    logic         tc_q, tc_d, irq_q, irq_d;
    logic         pre_en, pre_clr, tick, go;

    // Counting only happens in RUN on cycles with no load or stop
    assign pre_en = (state_q == RUN) && !stop && !load;

    timer_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    // Next state and datapath: load first, then stop, then start; decrement on tick
    always_comb begin
        eff      = load ? load_val : count_q;
        go       = start && (eff != '0);
        state_d  = state_q;
        count_d  = load ? load_val : count_q;
        reload_d = load ? load_val : reload_q;
        tc_d     = 1'b0;
        pre_clr  = load;
        if (state_q == RUN) begin
            if (load && load_val == '0) begin
                state_d = IDLE;
            end else if (stop) begin
                state_d = PAUSED;
            end else if (!load && tick) begin
                if (count_q > N'(1)) begin
                    count_d = count_q - 1'b1;
                end else if (count_q == N'(1)) begin
                    tc_d    = 1'b1;
                    count_d = auto_reload ? reload_q : '0;
                    state_d = auto_reload ? RUN : DONE;
                end
            end
        end else if (go) begin
            state_d = RUN;
            pre_clr = load || (state_q != PAUSED);
        end else if (load && state_q == DONE) begin
            state_d = IDLE;
        end
        irq_d = tc_d || (irq_q && !irq_clr);
    end

    // State, count, reload value, tc pulse and sticky irq registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            irq_q    <= irq_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign tc    = tc_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_timer_n.sv
// tb_timer_n: directed and random checks of two timer_n instances against a behavioural model
module tb_timer_n;

    localparam int MI = 0, MR = 1, MP = 2, MD = 3;

    typedef struct {
        int st;
        int cnt;
        int rl;
        int pre;
        int tc;
        int irq;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n, load, start, stop, ar, irq_clr;
    logic [7:0] lv;
    logic [3:0] c1;
    logic [7:0] c2;
    logic       b1, d1, t1, i1, b2, d2, t2, i2;
    int         checks = 0;
    int         errors = 0;
    mdl_t       m1, m2, mz;

    always #5 clk = ~clk;

    timer_n #(.N(4), .PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(lv[3:0]), .start(start),
        .stop(stop), .auto_reload(ar), .irq_clr(irq_clr),
        .count(c1), .busy(b1), .done(d1), .tc(t1), .irq(i1)
    );

    timer_n #(.N(8), .PRESCALE(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(lv), .start(start),
        .stop(stop), .auto_reload(ar), .irq_clr(irq_clr),
        .count(c2), .busy(b2), .done(d2), .tc(t2), .irq(i2)
    );

    function automatic mdl_t mstep(mdl_t m, int n, int p, bit ld, int v, bit st, bit sp, bit arl, bit clr);
        mdl_t r = m;
        int val = v & ((1 << n) - 1);
        int eff = ld ? val : m.cnt;
        r.tc = 0;
        if (ld) begin
            r.cnt = val;
            r.rl  = val;
            r.pre = 0;
        end
        if (m.st == MR) begin
            if (ld && val == 0) r.st = MI;
            else if (sp) r.st = MP;
            else if (!ld) begin
                if (m.pre == p - 1) begin
                    r.pre = 0;
                    if (m.cnt > 1) r.cnt = m.cnt - 1;
                    else if (m.cnt == 1) begin
                        r.tc  = 1;
                        r.cnt = arl ? m.rl : 0;
                        r.st  = arl ? MR : MD;
                    end
                end else r.pre = m.pre + 1;
            end
        end else if (st && eff != 0) begin
            r.st = MR;
            if (m.st != MP) r.pre = 0;
        end else if (ld && m.st == MD) r.st = MI;
        r.irq = (r.tc != 0 || (m.irq != 0 && !clr)) ? 1 : 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("m_count1", 32'(c1), m1.cnt);
        chk("m_busy1",  32'(b1), (m1.st == MR) ? 1 : 0);
        chk("m_done1",  32'(d1), (m1.st == MD) ? 1 : 0);
        chk("m_tc1",    32'(t1), m1.tc);
        chk("m_irq1",   32'(i1), m1.irq);
        chk("m_count2", 32'(c2), m2.cnt);
        chk("m_busy2",  32'(b2), (m2.st == MR) ? 1 : 0);
        chk("m_done2",  32'(d2), (m2.st == MD) ? 1 : 0);
        chk("m_tc2",    32'(t2), m2.tc);
        chk("m_irq2",   32'(i2), m2.irq);
    endtask

    task automatic step();
        @(posedge clk);
        m1 = mstep(m1, 4, 1, load, int'(lv), start, stop, ar, irq_clr);
        m2 = mstep(m2, 8, 4, load, int'(lv), start, stop, ar, irq_clr);
        #1;
        cmp_all();
    endtask

    task automatic idle_in();
        load = 1'b0; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_c1"}, 32'(c1), 0);
        chk({tag, "_b1"}, 32'(b1), 0);
        chk({tag, "_d1"}, 32'(d1), 0);
        chk({tag, "_t1"}, 32'(t1), 0);
        chk({tag, "_i1"}, 32'(i1), 0);
        chk({tag, "_c2"}, 32'(c2), 0);
        chk({tag, "_b2"}, 32'(b2), 0);
        chk({tag, "_i2"}, 32'(i2), 0);
    endtask

    initial begin
        mz = '{0, 0, 0, 0, 0, 0};
        m1 = mz;
        m2 = mz;
        rst_n = 1'b0; ar = 1'b0; lv = 8'd0;
        idle_in();
        #2;
        chk_zero("reset");
        #5 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold0", 32'(c1), 0);
        end
        // start with zero count is ignored
        start = 1'b1; step(); idle_in();
        chk("start0_busy", 32'(b1), 0);
        // one-shot countdown from 5
        lv = 8'd5; load = 1'b1; step(); idle_in();
        start = 1'b1; step(); idle_in();
        for (int i = 4; i >= 0; i--) begin
            step();
            chk("dn_count", 32'(c1), i);
            chk("dn_tc", 32'(t1), (i == 0) ? 1 : 0);
        end
        chk("dn_done", 32'(d1), 1);
        chk("dn_busy", 32'(b1), 0);
        chk("dn_irq", 32'(i1), 1);
        irq_clr = 1'b1; step(); idle_in();
        chk("irqclr", 32'(i1), 0);
        // auto-reload period 3, irq_clr coinciding with tc
        ar = 1'b1; lv = 8'd3; load = 1'b1; start = 1'b1; step(); idle_in();
        chk("ar_load", 32'(c1), 3);
        step(); chk("ar_c2", 32'(c1), 2);
        step(); chk("ar_c1", 32'(c1), 1);
        irq_clr = 1'b1; step(); idle_in();
        chk("ar_reload", 32'(c1), 3);
        chk("ar_tc", 32'(t1), 1);
        chk("set_wins", 32'(i1), 1);
        irq_clr = 1'b1; step(); idle_in();
        chk("clr_next", 32'(i1), 0);
        chk("ar_c2b", 32'(c1), 2);
        step(); step();
        chk("ar_reload2", 32'(c1), 3);
        chk("ar_busy", 32'(b1), 1);
        // stop and start together pause the count
        stop = 1'b1; start = 1'b1; step(); idle_in();
        chk("pause_busy", 32'(b1), 0);
        chk("pause_cnt", 32'(c1), 3);
        step(); step();
        chk("pause_hold", 32'(c1), 3);
        start = 1'b1; step(); idle_in();
        chk("resume_busy", 32'(b1), 1);
        // load during RUN takes effect with no decrement
        lv = 8'd7; load = 1'b1; step(); idle_in();
        chk("ld7", 32'(c1), 7);
        step();
        chk("ld7_dec", 32'(c1), 6);
        // load 0 during RUN returns to IDLE without tc
        lv = 8'd0; load = 1'b1; step(); idle_in();
        chk("ld0_busy", 32'(b1), 0);
        chk("ld0_tc", 32'(t1), 0);
        step();
        chk("ld0_tc2", 32'(t1), 0);
        // prescaled one-shot on dut2
        ar = 1'b0; lv = 8'd2; load = 1'b1; step(); idle_in();
        start = 1'b1; step(); idle_in();
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("ps_count", 32'(c2), (i < 4) ? 2 : (i < 8) ? 1 : 0);
            chk("ps_tc", 32'(t2), (i == 8) ? 1 : 0);
        end
        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            load    = ($urandom_range(0, 99) < 8);
            start   = ($urandom_range(0, 99) < 15);
            stop    = ($urandom_range(0, 99) < 5);
            irq_clr = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 5) ar = ~ar;
            lv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
            step();
        end
        idle_in();
        // asynchronous reset in the middle of a run
        ar = 1'b0; lv = 8'd9; load = 1'b1; step(); idle_in();
        start = 1'b1; step(); idle_in();
        step(); step();
        #3 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        m1 = mz;
        m2 = mz;
        #2 rst_n = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_c", 32'(c1), 0);
            chk("post_rst_b", 32'(b1), 0);
        end
        idle_in();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
